// File: rtl/main_memory_ctrl.sv
// Line-granular main-memory model with fixed per-phase access latency and Ready pulse.
// Optional MEM_STATS_EN adds saturating RdCount/WrCount outputs.
module main_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned LINE_W     = 512,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [LINE_W-1:0]     DataOut,
  output logic [LINE_W-1:0]     DataIn,
  output logic                  Ready,
  output logic                  Busy
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]           RdCount,
  output logic [31:0]           WrCount
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_t;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_rd_pend;
  logic [LINE_W-1:0] r_mem [DEPTH];
  logic              w_commit;
  logic              w_unused_addr;

  assign w_unused_addr = ^address[ADDR_WIDTH-1:IDX_W];

  // Reset gates the commit so an edge coinciding with reset never writes the array.
  assign w_commit = (r_state == WR_WAIT) && (r_cnt == '0) && !reset;

  always_ff @(posedge clock) begin
    if (w_commit) r_mem[r_idx] <= r_wdata;
  end

`ifdef MEM_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  assign RdCount = r_rd_count;
  assign WrCount = r_wr_count;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rd_pend <= 1'b0;
      DataIn    <= '0;
      Ready     <= 1'b0;
      Busy      <= 1'b0;
`ifdef MEM_STATS_EN
      r_rd_count <= '0;
      r_wr_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          Ready <= 1'b0;
          if (READ || WRITE) begin
            r_idx     <= address[IDX_W-1:0];
            r_wdata   <= DataOut;
            r_rd_pend <= READ;
            r_cnt     <= CNT_INIT;
            Busy      <= 1'b1;
            r_state   <= WRITE ? WR_WAIT : RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (r_cnt == '0) begin
`ifdef MEM_STATS_EN
            if (r_wr_count != '1) r_wr_count <= r_wr_count + 32'd1;
`endif
            if (r_rd_pend) begin
              r_cnt   <= CNT_INIT;
              r_state <= RD_WAIT;
            end else begin
              Busy    <= 1'b0;
              Ready   <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            DataIn  <= r_mem[r_idx];
            Busy    <= 1'b0;
            Ready   <= 1'b1;
            r_state <= DONE;
`ifdef MEM_STATS_EN
            if (r_rd_count != '1) r_rd_count <= r_rd_count + 32'd1;
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        DONE: begin
          Ready   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: two instances (LATENCY 4 and 1) against a transaction-level model.
module tb_main_memory_ctrl;

  localparam int LW = 512;
  localparam int DP = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [25:0]   addr;
  logic          rd, wr;
  logic [LW-1:0] dout;
  logic [LW-1:0] din0, din1;
  logic          rdy0, rdy1, bsy0, bsy1;
`ifdef MEM_STATS_EN
  logic [31:0]   rdc0, rdc1, wrc0, wrc1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  main_memory_ctrl #(.ADDR_WIDTH(26), .LINE_W(LW), .DEPTH(DP), .LATENCY(4)) dut0 (
    .clock(clk), .reset(rst), .address(addr), .READ(rd), .WRITE(wr), .DataOut(dout),
    .DataIn(din0), .Ready(rdy0), .Busy(bsy0)
`ifdef MEM_STATS_EN
    , .RdCount(rdc0), .WrCount(wrc0)
`endif
  );

  main_memory_ctrl #(.ADDR_WIDTH(26), .LINE_W(LW), .DEPTH(DP), .LATENCY(1)) dut1 (
    .clock(clk), .reset(rst), .address(addr), .READ(rd), .WRITE(wr), .DataOut(dout),
    .DataIn(din1), .Ready(rdy1), .Busy(bsy1)
`ifdef MEM_STATS_EN
    , .RdCount(rdc1), .WrCount(wrc1)
`endif
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Transaction-level model: each accepted request lasts (#phases * LATENCY) edges,
  // then one Ready cycle, then one more edge back to idle.
  bit            m_act  [2];
  int            m_age  [2];
  bit            m_w    [2];
  bit            m_r    [2];
  int            m_idx  [2];
  logic [LW-1:0] m_data [2];
  logic [LW-1:0] m_mem  [2][DP];
  bit            m_known[2][DP];
  logic [LW-1:0] m_din  [2];
  bit            m_dink [2];
  logic [31:0]   m_rdc  [2];
  logic [31:0]   m_wrc  [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int tot;
      if (rst) begin
        m_act[i] = 1'b0; m_din[i] = '0; m_dink[i] = 1'b1;
        m_rdc[i] = '0;   m_wrc[i] = '0;
      end else if (m_act[i]) begin
        m_age[i]++;
        tot = (int'(m_w[i]) + int'(m_r[i])) * lat_of(i);
        if (m_w[i] && m_age[i] == lat_of(i)) begin
          m_mem[i][m_idx[i]]   = m_data[i];
          m_known[i][m_idx[i]] = 1'b1;
          if (m_wrc[i] != 32'hFFFFFFFF) m_wrc[i]++;
        end
        if (m_r[i] && m_age[i] == tot) begin
          m_din[i]  = m_mem[i][m_idx[i]];
          m_dink[i] = m_known[i][m_idx[i]];
          if (m_rdc[i] != 32'hFFFFFFFF) m_rdc[i]++;
        end
        if (m_age[i] == tot + 1) m_act[i] = 1'b0;
      end else if (rd || wr) begin
        m_act[i]  = 1'b1;
        m_age[i]  = 0;
        m_w[i]    = wr;
        m_r[i]    = rd;
        m_idx[i]  = int'(addr) % DP;
        m_data[i] = dout;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int tot;
      logic eb, er;
      tot = (int'(m_w[i]) + int'(m_r[i])) * lat_of(i);
      eb = m_act[i] && (m_age[i] < tot);
      er = m_act[i] && (m_age[i] == tot);
      chk($sformatf("dut%0d Busy", i),  LW'(i == 0 ? bsy0 : bsy1), LW'(eb));
      chk($sformatf("dut%0d Ready", i), LW'(i == 0 ? rdy0 : rdy1), LW'(er));
      if (m_dink[i]) chk($sformatf("dut%0d DataIn", i), i == 0 ? din0 : din1, m_din[i]);
`ifdef MEM_STATS_EN
      chk($sformatf("dut%0d RdCount", i), LW'(i == 0 ? rdc0 : rdc1), LW'(m_rdc[i]));
      chk($sformatf("dut%0d WrCount", i), LW'(i == 0 ? wrc0 : wrc1), LW'(m_wrc[i]));
`endif
    end
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_wait();
    @(posedge clk); #2; rd = 1'b0; wr = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Issue one request, hold it until the selected instance pulses Ready, then drop it.
  task automatic req(input int sel, input bit r, input bit w, input logic [25:0] a,
                     input logic [LW-1:0] d, output int lat, output int bcnt);
    bit got;
    idle_wait();
    #2; rd = r; wr = w; addr = a; dout = d;
    @(posedge clk);
    lat = 0; bcnt = 0; got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if ((sel == 0) ? bsy0 : bsy1) bcnt++;
      if ((sel == 0) ? rdy0 : rdy1) begin got = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL ready timeout: dut%0d gave no Ready within 40 cycles", sel);
    end
    @(posedge clk); #2; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int lat, bc;
    logic [LW-1:0] l_dead, l_a5, l_1234, l_ones;
    l_dead = {16{32'hDEADBEEF}};
    l_a5   = {16{32'hA5A5A5A5}};
    l_1234 = {16{32'h12345678}};
    l_ones = '1;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset DataIn", din0, '0);
    chk("reset Ready", LW'(rdy0), '0);
    chk("reset Busy", LW'(bsy0), '0);
    @(posedge clk); #2; rst = 1'b0;

    req(0, 0, 1, 26'h10, l_dead, lat, bc);
    chk("write latency", LW'(lat), LW'(4));
    req(0, 1, 0, 26'h10, '0, lat, bc);
    chk("read latency", LW'(lat), LW'(4));
    chk("read busy cycles", LW'(bc), LW'(4));
    chk("read data", din0, l_dead);

    req(0, 1, 1, 26'h20, l_a5, lat, bc);
    chk("wr+rd latency", LW'(lat), LW'(8));
    chk("wr+rd data", din0, l_a5);

    req(0, 0, 1, 26'h400, l_1234, lat, bc);
    req(0, 1, 0, 26'h000, '0, lat, bc);
    chk("wrap data", din0, l_1234);

    req(0, 0, 1, 26'h30, '0, lat, bc);
    idle_wait();
    #2; wr = 1'b1; addr = 26'h30; dout = l_ones;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("mid-reset Busy", LW'(bsy0), '0);
    chk("mid-reset Ready", LW'(rdy0), '0);
    chk("mid-reset DataIn", din0, '0);
    @(posedge clk); #2; rst = 1'b0; wr = 1'b0;
    req(0, 1, 0, 26'h30, '0, lat, bc);
    chk("discarded write", din0, '0);

    req(1, 1, 0, 26'h10, '0, lat, bc);
    chk("lat1 read latency", LW'(lat), LW'(1));
    chk("lat1 read data", din1, l_dead);

`ifdef MEM_STATS_EN
    idle_wait();
    force dut0.r_rd_count = 32'hFFFFFFFF;
    m_rdc[0] = 32'hFFFFFFFF;
    @(posedge clk); #1; release dut0.r_rd_count;
    req(0, 1, 0, 26'h10, '0, lat, bc);
    chk("RdCount saturate", LW'(rdc0), LW'(32'hFFFFFFFF));
`endif

    // Random traffic: requests held or toggled at random, ignored while busy, rare resets.
    idle_wait();
    repeat (3000) begin
      @(posedge clk); #2;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        rd   = ($urandom_range(0, 2) != 0);
        wr   = ($urandom_range(0, 1) != 0);
        addr = {$urandom_range(0, 65535), 6'd0} | 26'($urandom_range(0, 15));
        dout = rand_line();
      end
    end
    rd = 1'b0; wr = 1'b0; rst = 1'b0;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

- Line-granular main-memory model and controller on the downstream side of the MainBus (MEM modport), serving the cache's line fills and dirty-line writebacks.
- Accepts a read, a write, or a combined writeback-then-fill request.
- Models a fixed, parameterised access latency.
- Signals completion with a one-cycle `Ready` pulse so the cache FSM can leave its evict/fill states.

## Interface
Parameters:
- `ADDR_WIDTH`, 26, line-address width (byte offset already stripped).
- `LINE_W`, 512, line width in bits; equals the bus `DATABUSWIDTH`.
- `DEPTH`, 1024, number of lines stored (power of two).
- `LATENCY`, 4, cycles per array access phase; legal range 1..255.

Ports:
- Reset is asynchronous and active-high.
- `clock  input  1  sole clock, posedge`
- `reset  input  1  asynchronous, active-high reset`
- `address  input  ADDR_WIDTH  line address from cache`
- `READ  input  1  line-fill request`
- `WRITE  input  1  writeback request`
- `DataOut  input  LINE_W  writeback data from cache`
- `DataIn  output  LINE_W  fill data to cache`
- `Ready  output  1  one-cycle completion pulse`
- `Busy  output  1  request in progress`

## Operation
- Array index is `address[$clog2(DEPTH)-1:0]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- Array contents are not reset. Reset clears only control state, `DataIn`, and the counters.
- FSM states: `IDLE`, `WR_WAIT`, `RD_WAIT`, `DONE`.
- In `IDLE`, a request is sampled on the edge where `READ|WRITE` is high:
  - Latch `address`, `DataOut`, and a pending-read flag (`rd_pend = READ`).
  - Load the counter with `LATENCY-1`.
  - Next state: `WR_WAIT` if `WRITE`, else `RD_WAIT`.
- Simultaneous `READ` and `WRITE`: always executed write-first, then read of the same latched address. The fill returns the just-written line. There is a single `Ready` at the end.
- `WR_WAIT`: decrement the counter each edge. On the edge where counter==0:
  - Commit the latched data to the array.
  - If `rd_pend`, go to `RD_WAIT` and reload the counter with `LATENCY-1`; else go to `DONE`.
- `RD_WAIT`: decrement the counter each edge. On the edge where counter==0, register the array line into `DataIn` and go to `DONE`.
- `DONE`: `Ready=1` for exactly this cycle; next state `IDLE`.
- `READ`/`WRITE` are ignored in every state except `IDLE`; no queueing.
- The cache holds the request until it sees `Ready` and drops it in the next cycle. A request still high when the FSM returns to `IDLE` is accepted as a new request.
- `Busy=1` in `WR_WAIT`/`RD_WAIT`, `0` in `IDLE`/`DONE`.
- `DataIn` holds its last value until the next read capture. A write-only request does not alter `DataIn`.
- Reset mid-operation: go to `IDLE` immediately, `Ready=0`, `Busy=0`. A write whose commit edge has not occurred is discarded (array unchanged). A committed write persists.
- Reset has priority over every same-edge event, including a commit.

## Timing
- Reset values: `DataIn=0`, `Ready=0`, `Busy=0`, state `IDLE`, counter 0; counters 0 when compiled in.
- Request accepted at edge E0:
  - Read-only: `DataIn` valid and `Ready=1` in the cycle following edge E(LATENCY).
  - Write-only: array updated at E(LATENCY); `Ready` in the cycle following it.
  - Write+read: commit at E(LATENCY), data and `Ready` in the cycle following E(2·LATENCY).
- `LATENCY=1`: counter loads 0, and each phase completes on the first edge after entry.
- Back-to-back throughput: one request per LATENCY+2 cycles (read or write only), given one `IDLE` cycle between requests.
- `Ready` is never asserted in two consecutive cycles.

## Configuration
- `MEM_STATS_EN` defined: adds two outputs, `RdCount` and `WrCount` (each `output 32`).
  - `RdCount` increments on each read capture; `WrCount` increments on each write commit.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- `MEM_STATS_EN` undefined: both ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- **Write then read:** `LATENCY=4`. Write `DataOut={16{32'hDEADBEEF}}` to address 0x10; after `Ready`, read 0x10 → `DataIn={16{32'hDEADBEEF}}`, `Ready` exactly 4 cycles after the read acceptance edge, `Busy` high for those 4 cycles.
- **Combined writeback + fill:** `READ=WRITE=1` at 0x20 with `{16{32'hA5A5A5A5}}` → single `Ready` after 8 cycles, `DataIn={16{32'hA5A5A5A5}}`; with stats, `WrCount` +1 and `RdCount` +1.
- **Wrap-around:** with `DEPTH=1024`, write `{16{32'h12345678}}` to 0x400, then read 0x000 → `{16{32'h12345678}}`.
- **Ignored requests:** toggle `READ` on another address during `WR_WAIT` → no extra `Ready`, array and `DataIn` unaffected; a held `READ` after `Ready` is re-accepted in `IDLE`.
- **Reset mid-write:** assert `reset` at accept+2 of a write to 0x30 (old contents `{16{32'h0}}`) → `Busy`/`Ready`/`DataIn`=0 asynchronously; a subsequent read of 0x30 returns `{16{32'h0}}`.
- **LATENCY=1 and saturation:** set `LATENCY=1`; a read completes with `Ready` one cycle after acceptance. With `MEM_STATS_EN`, force `RdCount` to 0xFFFFFFFF → it stays at 0xFFFFFFFF after another read.
